// File: rtl/product_bcd_converter.sv
// product_bcd_converter: handshaked iterative binary-to-BCD (double-dabble) converter
module product_bcd_converter #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones
);
  localparam int CW = $clog2(IN_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t          state, state_n;
  logic [IN_W-1:0] shreg;
  logic [11:0]     bcd, adj;
  logic [CW-1:0]   cnt;
  logic [11+IN_W:0] shifted;
  logic            last;
  // add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign shifted   = {adj, shreg} << 1;
  assign last      = cnt == CW'(1);
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: accept in IDLE, shift IN_W times, hold until consumed
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (in_valid ? CONV : IDLE) :
              (state == CONV) ? (last ? DONE : CONV) :
              (out_ready ? IDLE : DONE);
  end
  // datapath: load operand, shift with correction, capture digits on the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else if (state == IDLE && in_valid) begin
      shreg <= in_data;
      bcd   <= '0;
      cnt   <= CW'(IN_W);
    end else if (state == CONV) begin
      bcd   <= shifted[11+IN_W:IN_W];
      shreg <= shifted[IN_W-1:0];
      cnt   <= cnt - CW'(1);
      if (last) begin
        hundreds <= shifted[11+IN_W:8+IN_W];
        tens     <= shifted[7+IN_W:4+IN_W];
        ones     <= shifted[3+IN_W:IN_W];
      end
    end
  end
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: randomized and directed checks against a cycle-level reference model
module tb_product_bcd_converter;
  localparam int IN_W = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [IN_W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [3:0] hundreds, tens, ones;
  int checks = 0, failures = 0, cyc_n = 0;
  bit chk_en = 0;
  int m_rem = 0, m_val = 0, m_h = 0, m_t = 0, m_o = 0;
  bit m_ov = 0;

  product_bcd_converter #(.IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  always #5 clk = ~clk;

  // reference: accepted value appears as decimal digits IN_W cycles later, held until consumed
  always @(posedge clk) begin
    cyc_n++;
    if (rst) begin
      m_rem = 0; m_ov = 0; m_h = 0; m_t = 0; m_o = 0;
    end else if (m_ov) begin
      if (out_ready) m_ov = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_ov = 1; m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
      end
    end else if (in_valid) begin
      m_val = int'(in_data); m_rem = IN_W;
    end
  end

  // per-cycle comparison of every output against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_rdy;
      exp_rdy = !rst && m_rem == 0 && !m_ov;
      checks++;
      if ({in_ready, out_valid, hundreds, tens, ones} !==
          {exp_rdy, m_ov, 4'(m_h), 4'(m_t), 4'(m_o)}) begin
        failures++;
        $display("FAIL cycle %0d: got rdy=%b ov=%b %0d/%0d/%0d want rdy=%b ov=%b %0d/%0d/%0d",
                 cyc_n, in_ready, out_valid, hundreds, tens, ones, exp_rdy, m_ov, m_h, m_t, m_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 50) begin cyc(); k++; end
    chk("ready_wait", 32'(in_ready), 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin cyc(); lat++; end
  endtask

  task automatic directed(input int v, input int h, input int t, input int o);
    int lat;
    wait_ready();
    in_valid = 1; in_data = IN_W'(v);
    cyc();
    in_valid = 0;
    wait_valid(lat);
    chk($sformatf("lat_%0d", v), lat, 8);
    chk($sformatf("dig_%0d", v), {hundreds, tens, ones}, {4'(h), 4'(t), 4'(o)});
    cyc();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ov_cnt, last_acc;
    cyc();
    chk_en = 1;
    cyc(); cyc();
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 0;
    cyc();
    chk("rst_in_ready_after", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_digits", {hundreds, tens, ones}, 0);

    out_ready = 1;
    directed(0, 0, 0, 0);
    directed(9, 0, 0, 9);
    directed(99, 0, 9, 9);
    directed(225, 2, 2, 5);
    directed(255, 2, 5, 5);

    out_ready = 0;
    wait_ready();
    in_valid = 1; in_data = 144;
    cyc();
    in_valid = 0;
    wait_valid(lat);
    chk("bp_lat", lat, 8);
    repeat (5) begin
      cyc();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_digits", {hundreds, tens, ones}, {4'd1, 4'd4, 4'd4});
    end
    out_ready = 1;
    cyc();
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);

    wait_ready();
    in_valid = 1; in_data = 42;
    cyc();
    in_valid = 0;
    cyc(); cyc();
    in_valid = 1; in_data = 200;
    cyc();
    in_valid = 0;
    wait_valid(lat);
    chk("busy_digits", {hundreds, tens, ones}, {4'd0, 4'd4, 4'd2});
    cyc();
    ov_cnt = 0;
    repeat (12) begin cyc(); if (out_valid) ov_cnt++; end
    chk("busy_no_second", ov_cnt, 0);

    wait_ready();
    in_valid = 1; in_data = 250;
    cyc();
    in_valid = 0;
    cyc(); cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0;
    ov_cnt = 0;
    repeat (15) begin cyc(); if (out_valid) ov_cnt++; end
    chk("midrst_no_valid", ov_cnt, 0);
    chk("midrst_digits", {hundreds, tens, ones}, 0);
    directed(7, 0, 0, 7);

    out_ready = 1;
    last_acc = 0;
    for (int v = 0; v < 256; v++) begin
      wait_ready();
      in_data = IN_W'(v); in_valid = 1;
      cyc();
      if (v > 0) chk("sweep_spacing", cyc_n - last_acc, IN_W + 2);
      last_acc = cyc_n;
      wait_valid(lat);
      chk($sformatf("sweep_%0d", v), {hundreds, tens, ones},
          {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
      cyc();
    end
    in_valid = 0;

    repeat (3000) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = IN_W'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      rst       = $urandom_range(0, 150) == 0;
      cyc();
    end
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (20) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
